// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches one- or two-word instructions from a word-addressed
// instruction memory and presents them to decode with a valid/ready handshake.
// The first word's opcode field [2:0] decides the length: I_TYPE and M_TYPE carry
// a second (immediate) word, every other opcode is a single word.
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_cycles output, which
// counts cycles spent presenting an instruction that decode does not accept.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] instr,
    output logic [15:0] imm,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        halt,
    input  logic        pc_load,
    input  logic [15:0] pc_target
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    // Opcode field encoding shared with decode; only the two-word classes matter here.
    localparam logic [2:0] R_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] M_TYPE = 3'd2;

    typedef enum logic [2:0] {
        START   = 3'd0,
        FETCH0  = 3'd1,
        FETCH1  = 3'd2,
        PRESENT = 3'd3,
        HALTED  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] instr_q;
    logic [15:0] imm_q;
    logic [15:0] fetch_pc;
    logic        dword;
    logic        redirect;

    // Length decode of the word arriving from memory in FETCH0.
    assign dword    = (mem_rdata[2:0] == I_TYPE) || (mem_rdata[2:0] == M_TYPE);
    // A redirect wins over every other event except when halted.
    assign redirect = pc_load && (state != HALTED);

    assign mem_addr = pc;
    assign instr    = instr_q;
    assign imm      = imm_q;
    assign instr_pc = fetch_pc;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= START;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state;
        mem_re      = 1'b0;
        instr_valid = 1'b0;
        case (state)
            START: begin
                state_next = FETCH0;
            end
            FETCH0: begin
                mem_re = 1'b1;
                if (pc_load)
                    state_next = FETCH0;
                else if (mem_ready)
                    state_next = dword ? FETCH1 : PRESENT;
            end
            FETCH1: begin
                mem_re = 1'b1;
                if (pc_load)
                    state_next = FETCH0;
                else if (mem_ready)
                    state_next = PRESENT;
            end
            PRESENT: begin
                instr_valid = 1'b1;
                if (pc_load)
                    state_next = FETCH0;
                else if (instr_ready)
                    state_next = halt ? HALTED : FETCH0;
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = START;
            end
        endcase
    end

    // PC and fetched-word registers; words only latch on a completed read
    // that is not overridden by a redirect, so presented data stays stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr_q  <= 16'h0000;
            imm_q    <= 16'h0000;
            fetch_pc <= 16'h0000;
        end else if (redirect) begin
            pc <= pc_target;
        end else begin
            case (state)
                FETCH0: begin
                    if (mem_ready) begin
                        instr_q  <= mem_rdata;
                        fetch_pc <= pc;
                        pc       <= pc + 16'd1;
                        if (!dword)
                            imm_q <= 16'h0000;
                    end
                end
                FETCH1: begin
                    if (mem_ready) begin
                        imm_q <= mem_rdata;
                        pc    <= pc + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of cycles an instruction waits on decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cycles <= 16'h0000;
        else if (instr_valid && !instr_ready && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench for instruction_fetch with a
// transaction-level reference model (expected next instruction address and
// number of words already read for it).
module tb_instruction_fetch;

    localparam logic [15:0] RST_PC = 16'h0010;
    localparam logic [2:0]  OP_I   = 3'd1;
    localparam logic [2:0]  OP_M   = 3'd2;
    localparam int          NCYC   = 30000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halt = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .instr       (instr),
        .imm         (imm),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halt        (halt),
        .pc_load     (pc_load),
        .pc_target   (pc_target)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [15:0] mem [0:65535];

    function automatic bit is_dw(input logic [15:0] w);
        return (w[2:0] == OP_I) || (w[2:0] == OP_M);
    endfunction

    // Reference model: address of the next instruction to present, how many
    // of its words have been read (2 = complete), halted flag, stall count.
    logic [15:0] exp_pc;
    int          rd_idx;
    bit          m_halted;
    logic [15:0] m_stall;
    int          since_rst;
    int          halted_cyc;
    int          idle;
    int          phase = -1;
    int          cyc = 0;
    int          n_hs = 0;
    int          n_halts = 0;

    task automatic do_reset();
        reset       = 1'b1;
        pc_load     = 1'b0;
        halt        = 1'b0;
        instr_ready = 1'b0;
        mem_ready   = 1'b0;
        #1;
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'(RST_PC));
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_imm", 32'(imm), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif
        @(negedge clock);
        reset      = 1'b0;
        exp_pc     = RST_PC;
        rd_idx     = 0;
        m_halted   = 1'b0;
        m_stall    = 16'h0000;
        since_rst  = 0;
        halted_cyc = 0;
        idle       = 0;
        phase++;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] e_imm;
        bit          e_valid;
        bit          e_re;
        bit          zw;
        int          sel;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0010][2:0] = 3'd0;   // R_TYPE at the reset address
        mem[16'h0020][2:0] = OP_I;
        mem[16'hFFFF][2:0] = OP_M;   // double-word straddling the wrap

        @(negedge clock);
        do_reset();
        while (cyc < NCYC) begin
            zw = (phase == 0);
            e_valid = (rd_idx == 2) && !m_halted;
            e_re    = (rd_idx < 2) && !m_halted && (since_rst > 0);
            a       = exp_pc + 16'(rd_idx);

            // Observe: outputs reflect the state reached at the last edge.
            chk("mem_re", 32'(mem_re), 32'(e_re));
            chk("instr_valid", 32'(instr_valid), 32'(e_valid));
            if (e_re) chk("mem_addr", 32'(mem_addr), 32'(a));
            if (e_valid) begin
                e_imm = is_dw(mem[exp_pc]) ? mem[16'(exp_pc + 16'd1)] : 16'h0000;
                chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
                chk("instr", 32'(instr), 32'(mem[exp_pc]));
                chk("imm", 32'(imm), 32'(e_imm));
            end
`ifdef FETCH_STALL_CNT_EN
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif

            // Drive the inputs the DUT samples at the next rising edge.
            mem_ready   = zw ? 1'b1 : ($urandom_range(0, 2) == 0);
            mem_rdata   = mem_ready ? mem[mem_addr] : 16'($urandom);
            instr_ready = zw ? (since_rst != 5 && since_rst != 6) : 1'($urandom_range(0, 1));
            if (zw && since_rst < 12) instr_ready = (since_rst < 3) || (since_rst > 8);
            halt        = (since_rst > 4) && ($urandom_range(0, 29) == 0);
            pc_load     = (since_rst > 4 || m_halted) && ($urandom_range(0, 14) == 0);
            sel = $urandom_range(0, 4);
            case (sel)
                0: pc_target = 16'hFFFF;
                1: pc_target = 16'h0100;
                2: pc_target = 16'h0020;
                default: pc_target = 16'($urandom);
            endcase

            // Predict the effect of this edge at transaction level.
            if (e_valid && !instr_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (!m_halted) begin
                if (pc_load) begin
                    exp_pc = pc_target;
                    rd_idx = 0;
                end else begin
                    if (e_re && mem_ready)
                        rd_idx = (rd_idx == 0 && is_dw(mem[exp_pc])) ? 1 : 2;
                    if (e_valid && instr_ready) begin
                        exp_pc = exp_pc + (is_dw(mem[exp_pc]) ? 16'd2 : 16'd1);
                        rd_idx = 0;
                        idle   = 0;
                        n_hs++;
                        if (halt) begin
                            m_halted = 1'b1;
                            n_halts++;
                        end
                    end
                end
                idle++;
            end else begin
                halted_cyc++;
            end
            since_rst++;
            cyc++;

            if (idle > 200) begin
                checks++;
                errors++;
                $display("FAIL watchdog no handshake in %0d cycles t=%0t", idle, $time);
                do_reset();
            end else if (halted_cyc >= 20 || ($urandom_range(0, 499) == 0 && !zw)) begin
                do_reset();
            end else begin
                @(negedge clock);
            end
        end
        $display("handshakes %0d halts %0d phases %0d", n_hs, n_halts, phase);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the word address of the first fetch after reset.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port mem_addr, output, 16 bits: instruction memory word address.
REQ-005 The block SHALL have port mem_re, output, 1 bit: read request, held until mem_ready.
REQ-006 The block SHALL have port mem_rdata, input, 16 bits: read data, valid when mem_ready=1.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: read completes this cycle.
REQ-008 The block SHALL have port instr, output, 16 bits: first instruction word, to decode.
REQ-009 The block SHALL have port imm, output, 16 bits: second word of a double-word instruction, else 16'h0000.
REQ-010 The block SHALL have port instr_pc, output, 16 bits: address of the first word.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: instr/imm/instr_pc valid.
REQ-012 The block SHALL have port instr_ready, input, 1 bit: decode accepts this cycle.
REQ-013 The block SHALL have port halt, input, 1 bit: decode flags the presented instruction as SYS_END.
REQ-014 The block SHALL have port pc_load, input, 1 bit: redirect pulse from execute.
REQ-015 The block SHALL have port pc_target, input, 16 bits: redirect address.

Function
REQ-016 The FSM SHALL have states START, FETCH0, FETCH1, PRESENT and HALTED.
REQ-017 START SHALL go to FETCH0 unconditionally; mem_re=0 in START.
REQ-018 In FETCH0, mem_re=1 and mem_addr=pc; on mem_ready, latch mem_rdata into instr and set fetch_pc=pc.
REQ-019 On FETCH0 completion, if mem_rdata[2:0] is I_TYPE or M_TYPE (shared opcode_t encoding), go to FETCH1 with pc=pc+1.
REQ-020 On FETCH0 completion with any other opcode, clear imm to 0, set pc=pc+1, and go to PRESENT.
REQ-021 In FETCH1, mem_re=1 and mem_addr=pc; on mem_ready, latch imm, set pc=pc+1, and go to PRESENT.
REQ-022 instr_valid SHALL be 1 only in PRESENT; instr, imm and instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-023 In PRESENT with instr_ready=1 and halt=0, the next state SHALL be FETCH0.
REQ-024 In PRESENT with instr_ready=1 and halt=1, the next state SHALL be HALTED; halt is ignored when instr_valid=0 or instr_ready=0.
REQ-025 HALTED SHALL have mem_re=0 and instr_valid=0, and SHALL be left only by reset.
REQ-026 pc_load=1 in START, FETCH0, FETCH1 or PRESENT SHALL set pc=pc_target, drop any in-flight read or presented instruction (no handshake counted), and go to FETCH0 next cycle.
REQ-027 pc_load SHALL take priority over mem_ready, instr_ready and halt in the same cycle; pc_load SHALL be ignored in HALTED.
REQ-028 pc SHALL be 16 bits and wrap from 16'hFFFF to 16'h0000; a double-word instruction at 16'hFFFF SHALL take its second word from 16'h0000.
REQ-029 With a zero-wait memory (mem_ready=1 on the mem_re cycle), instr_valid SHALL assert 1 cycle after FETCH0 entry for single-word instructions and 2 cycles after for double-word instructions.

Reset
REQ-030 While reset=1: state=START, pc=RESET_PC, instr=0, imm=0, instr_pc=0, instr_valid=0, mem_re=0, mem_addr=RESET_PC.
REQ-031 Reset mid-fetch or mid-present SHALL abort immediately with no partial latch retained.

Configuration
REQ-032 With FETCH_STALL_CNT_EN defined, the block SHALL add output stall_cycles[15:0], reset 0, incrementing each cycle instr_valid=1 and instr_ready=0, saturating at 16'hFFFF and never cleared except by reset.
REQ-033 With FETCH_STALL_CNT_EN undefined, stall_cycles and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Reset release, RESET_PC=16'h0010, zero-wait memory, R_TYPE at 0x0010 -> mem_addr=0x0010; instr_valid 2 cycles after reset release with instr_pc=0x0010 and imm=0.
REQ-035 I_TYPE at 0x0020, word 0x1234 at 0x0021, mem_ready delayed 2 cycles per read -> instr_valid with imm=0x1234; next fetch at 0x0022.
REQ-036 instr_ready held 0 for 5 cycles in PRESENT -> outputs stable; stall_cycles=5 when FETCH_STALL_CNT_EN is defined.
REQ-037 pc_load=1 with pc_target=0x0100 during FETCH1 -> no instr_valid for the old instruction; next mem_addr=0x0100.
REQ-038 SYS_END presented with halt=1 and instr_ready=1 -> HALTED; mem_re stays 0 for 20 cycles even with pc_load pulses.
REQ-039 M_TYPE at 0xFFFF -> second read at 0x0000; the following fetch is at 0x0001.
